// File: rtl/bsh_pipe.sv
// bsh_pipe: log2(WIDTH)-stage pipelined barrel shifter with valid/ready
// handshake. Stage k conditionally shifts by 2^k; the whole pipe advances
// as one unit whenever the output slot is empty or being drained.

// One pipeline stage: conditional shift by 2^K, registered with its beat.
module bsh_stage #(
  parameter int WIDTH = 32,
  parameter int SH_W  = 5,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic [WIDTH-1:0] d_in,
  input  logic [SH_W-1:0]  sh_in,
  input  logic [1:0]       mode_in,
  output logic [WIDTH-1:0] d_out,
  output logic [SH_W-1:0]  sh_out,
  output logic [1:0]       mode_out
);
  localparam int AMT = 1 << K;

  logic [WIDTH-1:0] shf;
  logic [WIDTH-1:0] nxt;

  // Shift by this stage's fixed amount; arithmetic right replicates the
  // current MSB, which earlier stages have preserved as the original sign.
  always_comb begin
    shf = d_in;
    case (mode_in)
      2'b00:   shf = d_in << AMT;
      2'b01:   shf = d_in >> AMT;
      2'b10:   shf = $signed(d_in) >>> AMT;
      default: shf = (d_in >> AMT) | (d_in << (WIDTH - AMT));
    endcase
    nxt = sh_in[K] ? shf : d_in;
  end

  // Stage register; holds on stall, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out    <= '0;
      sh_out   <= '0;
      mode_out <= '0;
    end else if (adv) begin
      d_out    <= nxt;
      sh_out   <= sh_in;
      mode_out <= mode_in;
    end
  end
endmodule

module bsh_pipe #(
  parameter int WIDTH = 32,
  localparam int SH_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SH_W-1:0]  in_sh,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  if (WIDTH < 4 || WIDTH > 256 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("bsh_pipe: WIDTH must be a power of two in 4..256");
  end

  // Index 0 is the incoming beat; index k+1 is the register of stage k.
  logic [SH_W:0]            vld_pipe;
  logic [SH_W:0][WIDTH-1:0] dat_pipe;
  logic [SH_W:0][SH_W-1:0]  sh_pipe;
  logic [SH_W:0][1:0]       mode_pipe;
  logic                     adv;

  assign vld_pipe[0]  = in_valid;
  assign dat_pipe[0]  = in_data;
  assign sh_pipe[0]   = in_sh;
  assign mode_pipe[0] = in_mode;

  // Whole pipe moves together; the only backpressure source is the last slot.
  assign adv       = !vld_pipe[SH_W] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[SH_W];
  assign out_data  = dat_pipe[SH_W];
  assign busy      = |vld_pipe[SH_W:1];

  // Valid shift register; bubbles ride along exactly like beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_pipe[SH_W:1] <= '0;
    else if (adv) vld_pipe[SH_W:1] <= vld_pipe[SH_W-1:0];
  end

  for (genvar k = 0; k < SH_W; k++) begin : g_stage
    bsh_stage #(.WIDTH(WIDTH), .SH_W(SH_W), .K(k)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .d_in     (dat_pipe[k]),
      .sh_in    (sh_pipe[k]),
      .mode_in  (mode_pipe[k]),
      .d_out    (dat_pipe[k+1]),
      .sh_out   (sh_pipe[k+1]),
      .mode_out (mode_pipe[k+1])
    );
  end

  // The last stage's sh/mode have no consumer downstream.
  logic unused_tail;
  assign unused_tail = ^{sh_pipe[SH_W], mode_pipe[SH_W]};
endmodule

// File: doc/bsh_pipe.md
BSH_PIPE -- requirements
Module: bsh_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be a power of two in the range 4..256, any other value SHALL stop elaboration with an error.
REQ-002 Derived localparam SH_W = log2(WIDTH) (5 at default); this is the shift-amount width and the pipeline depth.
REQ-003 Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, input beat present.
REQ-006 Port in_ready, output, 1, block accepts the input beat this cycle.
REQ-007 Port in_data, input, WIDTH, operand.
REQ-008 Port in_sh, input, SH_W, shift amount 0..WIDTH-1.
REQ-009 Port in_mode, input, 2, operation: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
REQ-010 Port out_valid, output, 1, result beat present.
REQ-011 Port out_ready, input, 1, downstream accepts the result.
REQ-012 Port out_data, output, WIDTH, shifted result.
REQ-013 Port busy, output, 1, high while any pipeline stage holds a valid beat.

Function
REQ-014 Input transfer SHALL occur on a cycle with in_valid and in_ready both high; output transfer SHALL occur on a cycle with out_valid and out_ready both high.
REQ-015 The pipeline SHALL have SH_W registered stages; stage k (k = 0..SH_W-1) SHALL apply a shift of 2^k when bit k of the carried sh is 1, and a pass-through when it is 0.
REQ-016 Each stage SHALL carry its own valid bit, data, sh and mode fields; mode and sh SHALL travel with their beat, never shared across beats.
REQ-017 Logical left: vacated LSBs SHALL fill with 0; bits shifted past the MSB SHALL be discarded.
REQ-018 Logical right: vacated MSBs SHALL fill with 0.
REQ-019 Arithmetic right: vacated MSBs SHALL fill with the original bit WIDTH-1 of in_data.
REQ-020 Rotate right: bits leaving the LSB SHALL re-enter at the MSB; no bit is lost.
REQ-021 sh = 0 SHALL return in_data unchanged in every mode.
REQ-022 Advance condition: adv = !out_valid || out_ready; when adv is high, all stages SHALL shift one position; when adv is low, all stages SHALL hold their contents.
REQ-023 in_ready SHALL equal adv, combinationally; there is no other path from out_ready to in_ready.
REQ-024 Latency with no stall: a beat accepted in cycle N SHALL present out_valid in cycle N+SH_W; throughput SHALL be one beat per cycle.
REQ-025 Bubbles (stages with valid = 0) SHALL propagate as bubbles; beat order SHALL be preserved exactly.
REQ-026 Under a stall, out_data SHALL remain stable while out_valid is high and out_ready is low.
REQ-027 busy SHALL be the OR of all stage valid bits.

Reset
REQ-028 When rst_n is low, all stage valid bits, out_valid and busy SHALL be 0 and out_data SHALL be 0, immediately and without waiting for clk.
REQ-029 Reset mid-stream SHALL discard all in-flight beats, with no partial result emitted after release.
REQ-030 in_ready SHALL be high during and after reset, since out_valid is 0.
REQ-031 After rst_n is deasserted, the first accepted beat SHALL follow the REQ-024 latency exactly.

Verification
REQ-032 The bench SHALL cover the following scenarios at WIDTH=32.
- Mode 00, data 0x18A00000, sh 10 -> out_data 0x80000000 five cycles after acceptance.
- Mode 01, data 0x00FF0003, sh 20 -> 0x0000000F; mode 11, same data and sh -> 0xF000300F.
- Mode 10, data 0x80000000, sh 4 -> 0xF8000000; data 0x12345678, sh 0, every mode -> 0x12345678.
- Back-to-back stream of 8 beats with out_ready low for 3 cycles mid-stream -> in_ready low during the stall, all 8 results emitted in order, none duplicated or lost, out_data stable during the stall.
- rst_n pulsed low while 3 beats are in flight -> out_valid and busy go 0 immediately, no stale beat appears after release, and the next beat appears 5 cycles after acceptance.
- Random mode/sh/data for 10k beats with random out_ready -> matches the reference model; repeat at WIDTH=8 (latency 3) and WIDTH=64 (latency 6).
